// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results write back next cycle, long-latency results via a FIFO.
// Buffered heads that wait AGE_MAX cycles take priority over the ALU; LSU is back-pressured only when the FIFO is full.
module wb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int AGE_MAX    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   input  logic [4:0]                    alu_rd,
   input  logic [31:0]                   alu_data,
   output logic                          alu_ready,
   input  logic                          lsu_valid,
   input  logic [4:0]                    lsu_rd,
   input  logic [31:0]                   lsu_data,
   output logic                          lsu_ready,
   output logic                          we,
   output logic [4:0]                    a3,
   output logic [31:0]                   wd3,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(AGE_MAX + 1);

   logic [4:0]    rd_mem_q   [FIFO_DEPTH];
   logic [31:0]   data_mem_q [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] age_q, age_d;
   logic          we_q, we_d;
   logic [4:0]    a3_q, a3_d;
   logic [31:0]   wd3_q, wd3_d;

   logic          empty, starve, push, pop, alu_win;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   always_comb begin
      empty     = (cnt_q == '0);
      starve    = !empty && (age_q >= AW'(AGE_MAX));
      alu_ready = !starve;
      lsu_ready = (cnt_q < CW'(FIFO_DEPTH));
      push      = lsu_valid && lsu_ready;
      alu_win   = alu_valid && !starve;
      pop       = !empty && !alu_win;
      head_rd   = rd_mem_q[rd_ptr_q];
      head_data = data_mem_q[rd_ptr_q];

      // Full-FIFO readiness ignores a same-cycle pop, so push and pop never collide at full.
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      age_d = age_q;
      if (pop || empty)
         age_d = '0;
      else if (age_q < AW'(AGE_MAX))
         age_d = age_q + AW'(1);

      we_d  = 1'b0;
      a3_d  = a3_q;
      wd3_d = wd3_q;
      if (alu_win) begin
         we_d  = |alu_rd;
         a3_d  = alu_rd;
         wd3_d = alu_data;
      end else if (pop) begin
         we_d  = |head_rd;
         a3_d  = head_rd;
         wd3_d = head_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         age_q    <= '0;
         we_q     <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         age_q    <= age_d;
         we_q     <= we_d;
         a3_q     <= a3_d;
         wd3_q    <= wd3_d;
      end
   end

   // Storage needs no reset: the pointers and count decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= lsu_rd;
         data_mem_q[wr_ptr_q] <= lsu_data;
      end
   end

   assign we         = we_q;
   assign a3         = a3_q;
   assign wd3        = wd3_q;
   assign fifo_count = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: a queue-based reference model predicts each post-edge state.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int AMAX  = 4;

   logic        clk, rst;
   logic        alu_valid, lsu_valid, alu_ready, lsu_ready, we;
   logic [4:0]  alu_rd, lsu_rd, a3;
   logic [31:0] alu_data, lsu_data, wd3;
   logic [2:0]  fifo_count;

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .AGE_MAX(AMAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .we(we), .a3(a3), .wd3(wd3), .fifo_count(fifo_count)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd3;
      logic        alu_rdy;
      logic        lsu_rdy;
      int          cnt;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   int          m_age;
   logic [4:0]  m_a3;
   logic [31:0] m_wd3;
   int          n_chk, n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] rnd_rd();
      if ($urandom_range(0, 3) == 0) return 5'd0;
      return 5'($urandom_range(1, 31));
   endfunction

   // One cycle: drive inputs at negedge, advance the model across the coming posedge.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       output logic lacc);
      bit   starve, was_empty, popped;
      ent_t h, n;
      exp_t e;
      @(negedge clk);
      alu_valid = av; alu_rd = ard; alu_data = adat;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;

      was_empty = (mq.size() == 0);
      starve    = !was_empty && (m_age >= AMAX);
      lacc      = lv && (mq.size() < DEPTH);
      popped    = 0;
      e.we      = 1'b0;
      if (av && !starve) begin
         e.we = (ard != 0); m_a3 = ard; m_wd3 = adat;
      end else if (!was_empty) begin
         h = mq.pop_front();
         popped = 1;
         e.we = (h.rd != 0); m_a3 = h.rd; m_wd3 = h.d;
      end
      if (popped || was_empty) m_age = 0;
      else if (m_age < AMAX) m_age = m_age + 1;
      if (lacc) begin
         n.rd = lrd; n.d = ldat;
         mq.push_back(n);
      end
      e.a3      = m_a3;
      e.wd3     = m_wd3;
      e.alu_rdy = !((mq.size() > 0) && (m_age >= AMAX));
      e.lsu_rdy = (mq.size() < DEPTH);
      e.cnt     = mq.size();
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("we", 32'(we), 32'(e.we));
         check("a3", 32'(a3), 32'(e.a3));
         check("wd3", wd3, e.wd3);
         check("alu_ready", 32'(alu_ready), 32'(e.alu_rdy));
         check("lsu_ready", 32'(lsu_ready), 32'(e.lsu_rdy));
         check("fifo_count", 32'(fifo_count), 32'(e.cnt));
      end
   end

   task automatic model_reset();
      mq.delete();
      m_age = 0; m_a3 = '0; m_wd3 = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, pv, av;
      logic [4:0]  prd;
      logic [31:0] pd;
      n_chk = 0; n_fail = 0;
      model_reset();
      rst = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h66;
      repeat (3) @(posedge clk);
      #2;
      check("rst_we", 32'(we), 0);
      check("rst_a3", 32'(a3), 0);
      check("rst_wd3", wd3, 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_alu_ready", 32'(alu_ready), 1);
      check("rst_lsu_ready", 32'(lsu_ready), 1);
      @(negedge clk);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      rst = 1'b0;

      // ALU write and x0 discard
      step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, acc);
      step(1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, acc);
      step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

      // Starvation of a single buffered head under continuous ALU traffic
      step(1, 5'd1, 32'h100, 1, 5'd3, 32'h77, acc);
      for (int i = 0; i < 7; i++) step(1, 5'(i + 2), 32'h200 + i, 0, 5'd0, 32'h0, acc);
      repeat (3) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

      // Fill to full, then push against full while a starving pop occurs
      for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 32'h300 + i, 1, 5'(10 + i), 32'hA0 + i, acc);
      for (int i = 0; i < 2; i++) step(1, 5'd20, 32'h400 + i, 1, 5'd25, 32'hBB, acc);
      repeat (6) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);
      // Six pushes through the wrap
      for (int i = 0; i < 6; i++) step(0, 5'd0, 32'h0, 1, 5'(16 + i), 32'hC0 + i, acc);
      repeat (3) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

      // Same-cycle push and pop at count 2
      for (int i = 0; i < 2; i++) step(1, 5'd4, 32'h500 + i, 1, 5'(6 + i), 32'hD0 + i, acc);
      step(0, 5'd0, 32'h0, 1, 5'd8, 32'hD2, acc);
      repeat (5) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

      // Randomized traffic with LSU offers held until accepted
      pv = 0; prd = '0; pd = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!pv && $urandom_range(0, 2) != 0) begin
            pv = 1; prd = rnd_rd(); pd = $urandom;
         end
         av = ($urandom_range(0, 3) != 0);
         step(av, rnd_rd(), $urandom, pv, prd, pd, acc);
         if (acc) pv = 0;
      end
      repeat (30) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

      // Asynchronous reset with three entries buffered
      for (int i = 0; i < 3; i++) step(1, 5'd2, 32'h600 + i, 1, 5'(11 + i), 32'hE0 + i, acc);
      @(posedge clk);
      #3;
      rst = 1'b1;
      alu_valid = 1'b0; lsu_valid = 1'b0;
      #1;
      check("async_rst_we", 32'(we), 0);
      check("async_rst_count", 32'(fifo_count), 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);
      step(1, 5'd9, 32'hCAFE0001, 0, 5'd0, 32'h0, acc);

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
